event_encoder_16_4: RTL and testbench

EVENT_ENCODER_16_4 -- requirements
Module: event_encoder_16_4

---
 rtl/hwag_enc_pkg.sv | 22 ++
 rtl/priority_encoder_16_4.sv | 24 ++
 rtl/event_encoder_16_4.sv | 149 ++++++++++++++
 tb/tb_event_encoder_16_4.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_enc_pkg.sv
// Shared definitions for the 16-to-4 event encoder.
//   enc_state_e : presenter state (IDLE, PRESENT)
//   ENC_IN_W    : number of event lines
//   ENC_CODE_W  : width of an event index
//   code_add    : index addition modulo ENC_IN_W
package hwag_enc_pkg;

    localparam int unsigned ENC_IN_W   = 16;
    localparam int unsigned ENC_CODE_W = 4;

    typedef enum logic {
        IDLE,
        PRESENT
    } enc_state_e;

    // ENC_IN_W is a power of two, so plain truncation gives the modulo.
    function automatic logic [ENC_CODE_W-1:0] code_add(input logic [ENC_CODE_W-1:0] a,
                                                       input logic [ENC_CODE_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/priority_encoder_16_4.sv
// Combinational 16-to-4 priority encoder; the lowest set bit wins.
//   in   : request vector
//   code : index of the lowest set bit (0 when nothing is set)
//   any  : at least one bit of in is set
module priority_encoder_16_4
    import hwag_enc_pkg::*;
(
    input  logic [ENC_IN_W-1:0]   in,
    output logic [ENC_CODE_W-1:0] code,
    output logic                  any
);

    always_comb begin
        code = '0;
        any  = |in;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = ENC_IN_W - 1; i >= 0; i--) begin
            if (in[i]) begin
                code = ENC_CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder_16_4.sv
// Event encoder: captures events on 16 request lines into a pending register, and
// presents one eligible (pending & mask) event at a time as a 4-bit code with a
// valid/ack handshake. Re-arrival of a pending event sets a sticky overrun flag.
//   EDGE        : 1 = rising-edge capture, 0 = level capture
//   clk         : clock, rising edge
//   n_rst       : asynchronous active-low reset
//   in          : event request lines
//   mask        : per-line eligibility
//   out_code    : index of the presented event
//   out_valid   : out_code holds a valid event
//   out_ack     : consumer accepts the presented event
//   pending     : latched, unserviced events
//   overrun     : sticky, an event re-arrived while pending (edge mode only)
//   overrun_clr : clears overrun
// Build option: define EVENT_ENCODER_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest eligible index always wins.
module event_encoder_16_4
    import hwag_enc_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [ENC_IN_W-1:0]   in,
    input  logic [ENC_IN_W-1:0]   mask,
    output logic [ENC_CODE_W-1:0] out_code,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [ENC_IN_W-1:0]   pending,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    enc_state_e            state_q;
    logic [ENC_CODE_W-1:0] out_code_q;
    logic                  out_valid_q;
    logic [ENC_IN_W-1:0]   in_d_q;
    logic                  armed_q;
    logic [ENC_IN_W-1:0]   pending_q, pending_d;
    logic                  overrun_q, overrun_d;

    logic [ENC_IN_W-1:0]   set, clr, eligible, rotated;
    logic                  accept;
    logic [ENC_CODE_W-1:0] offset, enc_code, win_code;
    logic                  enc_any;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [ENC_CODE_W-1:0] last_q;
    assign offset = code_add(last_q, ENC_CODE_W'(1));
`else
    assign offset = '0;
`endif

    // Capture. armed_q is low for the first edge after reset so that a line
    // already high at reset release is loaded into in_d_q rather than seen as
    // a fresh rising edge.
    always_comb begin
        set = '0;
        if (!EDGE) begin
            set = in;
        end else if (armed_q) begin
            set = in & ~in_d_q;
        end
    end

    assign accept = (state_q == PRESENT) && out_ack;

    always_comb begin
        clr = '0;
        if (accept) begin
            clr[out_code_q] = 1'b1;
        end
    end

    // A simultaneous set wins over clr, and only counts as overrun if the bit
    // was pending and not being serviced this cycle.
    always_comb begin
        pending_d = (pending_q & ~clr) | set;
        overrun_d = (EDGE && (|(set & pending_q & ~clr))) || (overrun_q && !overrun_clr);
    end

    // Arbitration: rotate the eligible vector right by offset, pick the lowest
    // bit, then add the offset back to recover the real index.
    assign eligible = pending_q & mask;

    always_comb begin
        for (int i = 0; i < ENC_IN_W; i++) begin
            rotated[i] = eligible[code_add(ENC_CODE_W'(i), offset)];
        end
    end

    priority_encoder_16_4 u_prio (
        .in   (rotated),
        .code (enc_code),
        .any  (enc_any)
    );

    assign win_code = code_add(enc_code, offset);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_d_q    <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            in_d_q    <= in;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            last_q      <= ENC_CODE_W'(ENC_IN_W - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_any) begin
                        out_code_q  <= win_code;
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ack) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
                        last_q      <= out_code_q;
`endif
                    end
                end
            endcase
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_event_encoder_16_4.sv
// Bench for event_encoder_16_4: an edge-mode and a level-mode instance share the
// stimulus; a behavioural model tracks both and is compared every cycle, and
// directed scenarios pin hand-computed values.
module tb_event_encoder_16_4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [15:0] in_s;
    logic [15:0] mask;
    logic        out_ack;
    logic        overrun_clr;

    logic [3:0]  code_a, code_b;
    logic        valid_a, valid_b;
    logic [15:0] pend_a, pend_b;
    logic        ovr_a, ovr_b;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    event_encoder_16_4 #(.EDGE(1'b1)) dut_a (
        .clk         (clk),
        .n_rst       (n_rst),
        .in          (in_s),
        .mask        (mask),
        .out_code    (code_a),
        .out_valid   (valid_a),
        .out_ack     (out_ack),
        .pending     (pend_a),
        .overrun     (ovr_a),
        .overrun_clr (overrun_clr)
    );

    event_encoder_16_4 #(.EDGE(1'b0)) dut_b (
        .clk         (clk),
        .n_rst       (n_rst),
        .in          (in_s),
        .mask        (mask),
        .out_code    (code_b),
        .out_valid   (valid_b),
        .out_ack     (out_ack),
        .pending     (pend_b),
        .overrun     (ovr_b),
        .overrun_clr (overrun_clr)
    );

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Model state, index 0 = edge-mode instance, 1 = level-mode instance.
    bit m_pend [2][16];
    bit m_prev [2][16];
    bit m_armed [2];
    bit m_valid [2];
    bit m_ovr [2];
    int m_code [2];
    int m_last [2];

    always @(posedge clk or negedge n_rst) begin : model
        bit s, c, hit;
        int start, found, idx;
        if (!n_rst) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] <= 1'b0;
                m_code[k]  <= 0;
                m_ovr[k]   <= 1'b0;
                m_last[k]  <= 15;
                m_armed[k] <= 1'b0;
                for (int i = 0; i < 16; i++) begin
                    m_pend[k][i] <= 1'b0;
                    m_prev[k][i] <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                hit = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (k == 0) s = m_armed[k] && in_s[i] && !m_prev[k][i];
                    else        s = in_s[i];
                    c = m_valid[k] && out_ack && (m_code[k] == i);
                    if (k == 0 && s && m_pend[k][i] && !c) hit = 1'b1;
                    m_pend[k][i] <= (m_pend[k][i] && !c) || s;
                    m_prev[k][i] <= in_s[i];
                end
                m_armed[k] <= 1'b1;
                m_ovr[k] <= hit || (m_ovr[k] && !overrun_clr);
                if (!m_valid[k]) begin
                    start = RR ? (m_last[k] + 1) % 16 : 0;
                    found = -1;
                    for (int j = 0; j < 16; j++) begin
                        idx = (start + j) % 16;
                        if (found < 0 && m_pend[k][idx] && mask[idx]) found = idx;
                    end
                    if (found >= 0) begin
                        m_code[k]  <= found;
                        m_valid[k] <= 1'b1;
                    end
                end else if (out_ack) begin
                    m_valid[k] <= 1'b0;
                    m_last[k]  <= m_code[k];
                end
            end
        end
    end

    function automatic logic [15:0] model_pend(input int k);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_pend[k][i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model; outputs only move on posedge
    // or reset, so the falling edge is a stable sampling point.
    always @(negedge clk) begin
        if ($time > 5) begin
            check("model code_a",  32'(code_a),  32'(m_code[0]));
            check("model valid_a", 32'(valid_a), 32'(m_valid[0]));
            check("model pend_a",  32'(pend_a),  32'(model_pend(0)));
            check("model ovr_a",   32'(ovr_a),   32'(m_ovr[0]));
            check("model code_b",  32'(code_b),  32'(m_code[1]));
            check("model valid_b", 32'(valid_b), 32'(m_valid[1]));
            check("model pend_b",  32'(pend_b),  32'(model_pend(1)));
            check("model ovr_b",   32'(ovr_b),   32'(m_ovr[1]));
        end
    end

    // One clock: returns just after the following falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        mask    = 16'hFFFF;
        out_ack = 1'b1;
        repeat (40) cyc();
        out_ack = 1'b0;
        cyc();
    endtask

    initial begin
        in_s        = '0;
        mask        = 16'hFFFF;
        out_ack     = 1'b0;
        overrun_clr = 1'b0;
        #2 n_rst = 1'b0;
        cyc();
        cyc();
        check("reset valid", 32'(valid_a), 32'd0);
        check("reset code",  32'(code_a),  32'd0);
        check("reset pend",  32'(pend_a),  32'd0);
        check("reset ovr",   32'(ovr_a),   32'd0);
        n_rst = 1'b1;
        cyc();

        // Two events from one pulse, served lowest first.
        in_s = 16'h0024; cyc();
        check("pulse pend", 32'(pend_a), 32'h24);
        check("pulse not yet valid", 32'(valid_a), 32'd0);
        in_s = '0; cyc();
        check("first code", 32'(code_a), 32'd2);
        check("first valid", 32'(valid_a), 32'd1);
        out_ack = 1'b1; cyc();
        check("after ack valid", 32'(valid_a), 32'd0);
        check("after ack pend", 32'(pend_a), 32'h20);
        out_ack = 1'b0; cyc();
        check("second code", 32'(code_a), 32'd5);
        check("second valid", 32'(valid_a), 32'd1);
        out_ack = 1'b1; cyc();
        check("drained valid", 32'(valid_a), 32'd0);
        check("drained pend", 32'(pend_a), 32'd0);
        out_ack = 1'b0; cyc();

        // Extreme indices with ack held high.
        in_s = 16'h8001; cyc();
        in_s = '0; out_ack = 1'b1; cyc();
        check("8001 first", 32'(code_a), 32'd0);
        cyc();
        check("8001 gap valid", 32'(valid_a), 32'd0);
        check("8001 gap pend", 32'(pend_a), 32'h8000);
        cyc();
        check("8001 second", 32'(code_a), 32'd15);
        check("8001 second valid", 32'(valid_a), 32'd1);
        cyc();
        check("8001 empty", 32'(pend_a), 32'd0);
        out_ack = 1'b0; cyc();

        // Grant index 0, then offer 0 and 1 together.
        in_s = 16'h0001; cyc();
        in_s = '0; cyc();
        out_ack = 1'b1; cyc();
        out_ack = 1'b0; in_s = 16'h0003; cyc();
        in_s = '0; cyc();
        check("arb first", 32'(code_a), RR ? 32'd1 : 32'd0);
        out_ack = 1'b1; cyc(); cyc();
        check("arb second", 32'(code_a), RR ? 32'd0 : 32'd1);
        cyc();
        out_ack = 1'b0; cyc();

        // Overrun on a held (masked) pending bit.
        mask = '0;
        in_s = 16'h0008; cyc();
        check("bit3 pend", 32'(pend_a), 32'h8);
        in_s = '0; cyc();
        in_s = 16'h0008; cyc();
        check("overrun edge", 32'(ovr_a), 32'd1);
        check("overrun level mode", 32'(ovr_b), 32'd0);
        in_s = '0; overrun_clr = 1'b1; cyc();
        check("overrun cleared", 32'(ovr_a), 32'd0);
        overrun_clr = 1'b0;
        in_s = 16'h0008; cyc();
        in_s = '0; cyc();
        in_s = 16'h0008; overrun_clr = 1'b1; cyc();
        check("new overrun beats clr", 32'(ovr_a), 32'd1);
        in_s = '0; cyc();
        check("clr after collision", 32'(ovr_a), 32'd0);
        overrun_clr = 1'b0;

        // Rising edge in the very cycle bit 3 is acknowledged.
        mask = 16'h0008; cyc();
        check("bit3 code", 32'(code_a), 32'd3);
        check("bit3 valid", 32'(valid_a), 32'd1);
        in_s = 16'h0008; out_ack = 1'b1; cyc();
        check("set beats clr pend", 32'(pend_a), 32'h8);
        check("set beats clr ovr", 32'(ovr_a), 32'd0);
        in_s = '0; out_ack = 1'b0; cyc();
        check("bit3 again", 32'(code_a), 32'd3);
        out_ack = 1'b1; cyc();
        out_ack = 1'b0; cyc();
        check("bit3 gone", 32'(pend_a), 32'd0);

        // Masked pending bit waits, then goes as soon as it is unmasked.
        mask = '0;
        in_s = 16'h0010; cyc();
        in_s = '0; cyc(); cyc();
        check("masked valid", 32'(valid_a), 32'd0);
        check("masked pend", 32'(pend_a), 32'h10);
        mask = 16'h0010; cyc();
        check("unmasked code", 32'(code_a), 32'd4);
        check("unmasked valid", 32'(valid_a), 32'd1);
        out_ack = 1'b1; cyc();
        out_ack = 1'b0; mask = 16'hFFFF; cyc();

        // Presentation holds while mask and inputs change.
        in_s = 16'h0006; cyc();
        in_s = '0; cyc();
        check("hold code", 32'(code_a), 32'd1);
        mask = 16'h0004; in_s = 16'h0001; cyc();
        in_s = '0; cyc();
        check("hold code stable", 32'(code_a), 32'd1);
        check("hold valid stable", 32'(valid_a), 32'd1);
        check("hold pend", 32'(pend_a), 32'h7);
        out_ack = 1'b1; cyc();
        check("hold released", 32'(valid_a), 32'd0);
        out_ack = 1'b0; cyc();
        check("masked winner", 32'(code_a), 32'd2);
        drain();

        // Reset in the middle of a presentation with the input held high.
        in_s = 16'h00F0; cyc();
        in_s = '0; cyc();
        check("pre-reset code", 32'(code_a), 32'd4);
        in_s = 16'h0100; cyc();
        n_rst = 1'b0; #1;
        check("async valid", 32'(valid_a), 32'd0);
        check("async code", 32'(code_a), 32'd0);
        check("async pend", 32'(pend_a), 32'd0);
        check("async pend b", 32'(pend_b), 32'd0);
        cyc();
        n_rst = 1'b1; cyc(); cyc();
        check("no capture after reset", 32'(pend_a), 32'd0);
        check("no present after reset", 32'(valid_a), 32'd0);
        check("level captures after reset", 32'(pend_b), 32'h100);
        in_s = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
